frank_control_unit: RTL and testbench

- Instruction-sequencing control unit of the FRANK6000 8-bit CPU.
- Steps a 2-bit FSM through FETCH / CYCLE1 / CYCLE2 and decodes the 4-bit opcode into 16 datapath strobes and mux selects.
- Strobes drive the PC/stack, ADDR, FR, WREG, ALU and STATUS blocks.
- Outputs are combinational (Mealy) on the current state and `control_input`.

---
 rtl/frank_control_unit_if.sv | 39 +++
 rtl/frank_control_unit.sv | 120 ++++++++++++
 tb/tb_frank_control_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/frank_control_unit_if.sv
// Control bus between the FRANK6000 control unit and its datapath.
// Ports carried:
//   control_input  opcode from the instruction register (datapath -> control unit)
//   jump, j_mode   PC jump request and condition select
//   call, ret      stack push / pop of the return address ("return" is a keyword)
//   ADDRin, FRin   ADDR and FR source selects
//   WREGin         WREG source select
//   ALUin1, ALUin2 ALU operand selects
//   PCw, ADDRw, FRw, WREGw, STATUSw  register write enables
// master: control unit side. slave: datapath side.
interface frank_control_unit_if;
  logic [3:0] control_input;
  logic       jump;
  logic [1:0] j_mode;
  logic       call;
  logic       ret;
  logic       ADDRin;
  logic       FRin;
  logic [1:0] WREGin;
  logic       ALUin1;
  logic       ALUin2;
  logic       PCw;
  logic       ADDRw;
  logic       FRw;
  logic       WREGw;
  logic       STATUSw;

  modport master (
    input  control_input,
    output jump, j_mode, call, ret, ADDRin, FRin, WREGin, ALUin1, ALUin2,
    output PCw, ADDRw, FRw, WREGw, STATUSw
  );

  modport slave (
    output control_input,
    input  jump, j_mode, call, ret, ADDRin, FRin, WREGin, ALUin1, ALUin2,
    input  PCw, ADDRw, FRw, WREGw, STATUSw
  );
endinterface

// File: rtl/frank_control_unit.sv
// Instruction-sequencing control unit of the FRANK6000 8-bit CPU.
// Steps FETCH -> CYCLE1 (-> CYCLE2 for the two-execute-cycle opcodes) and
// decodes the opcode into datapath strobes, combinationally on state and opcode.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  control bus (master side): opcode in, strobes and selects out
module frank_control_unit (
  input  logic                        clk,
  input  logic                        rst,
  frank_control_unit_if.master        bus
);

  typedef enum logic [1:0] {
    StCycle2  = 2'b00,
    StFetch   = 2'b01,
    StCycle1  = 2'b10,
    StIllegal = 2'b11
  } unit_state_e;

  // Opcodes
  localparam logic [3:0] OpCalls = 4'h1;
  localparam logic [3:0] OpRet   = 4'h2;
  localparam logic [3:0] OpJmp   = 4'h3;
  localparam logic [3:0] OpJz    = 4'h4;
  localparam logic [3:0] OpJc    = 4'h5;
  localparam logic [3:0] OpLda   = 4'h6;
  localparam logic [3:0] OpLdw   = 4'h7;
  localparam logic [3:0] OpMovwf = 4'h8;
  localparam logic [3:0] OpMovfw = 4'h9;
  localparam logic [3:0] OpWtoa  = 4'hA;
  localparam logic [3:0] OpR1Alu = 4'hB;
  localparam logic [3:0] OpR2Flr = 4'hC;
  localparam logic [3:0] OpR2Flw = 4'hD;

  // Output words {jump, j_mode, call, ret, ADDRin, FRin, WREGin, ALUin1, ALUin2,
  //               PCw, ADDRw, FRw, WREGw, STATUSw}
  localparam logic [15:0] OCallsF  = 16'hB010;
  localparam logic [15:0] ORetF    = 16'h0810;
  localparam logic [15:0] OJmpF    = 16'h8010;
  localparam logic [15:0] OJzF     = 16'hC010;
  localparam logic [15:0] OJcF     = 16'hE010;
  localparam logic [15:0] OLdaC1   = 16'h0008;
  localparam logic [15:0] OLdwC1   = 16'h0082;
  localparam logic [15:0] OMovwfC1 = 16'h0004;
  localparam logic [15:0] OMovfwC1 = 16'h0102;
  localparam logic [15:0] OWtoaC1  = 16'h0408;
  localparam logic [15:0] OR1AluC1 = 16'h0043;
  localparam logic [15:0] OR2FlrC1 = 16'h0033;
  localparam logic [15:0] OR2FlwC1 = 16'h0021;
  localparam logic [15:0] OR2FlwC2 = 16'h0204;

  unit_state_e r_unit_state, next_state;
  logic        r_c2, next_c2;
  logic [15:0] o_word;
  logic [3:0]  op;

  assign op = bus.control_input;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_unit_state <= StCycle2;
      r_c2         <= 1'b0;
    end else begin
      r_unit_state <= next_state;
      r_c2         <= next_c2;
    end
  end

  always_comb begin
    next_state = StFetch;
    next_c2    = 1'b0;
    o_word     = 16'h0000;
    unique case (r_unit_state)
      StFetch: begin
        next_state = StCycle1;
        case (op)
          OpCalls: o_word = OCallsF;
          OpRet:   o_word = ORetF;
          OpJmp:   o_word = OJmpF;
          OpJz:    o_word = OJzF;
          OpJc:    o_word = OJcF;
          default: o_word = 16'h0000;
        endcase
      end
      StCycle1: begin
        if (op == OpR2Flr || op == OpR2Flw) begin
          next_state = StCycle2;
          next_c2    = 1'b1;
        end
        case (op)
          OpLda:   o_word = OLdaC1;
          OpLdw:   o_word = OLdwC1;
          OpMovwf: o_word = OMovwfC1;
          OpMovfw: o_word = OMovfwC1;
          OpWtoa:  o_word = OWtoaC1;
          OpR1Alu: o_word = OR1AluC1;
          OpR2Flr: o_word = OR2FlrC1;
          OpR2Flw: o_word = OR2FlwC1;
          default: o_word = 16'h0000;
        endcase
      end
      StCycle2: begin
        // The post-reset CYCLE2 has r_c2 clear and must stay silent.
        if (r_c2 && op == OpR2Flw) o_word = OR2FlwC2;
      end
      StIllegal: begin
        next_state = StFetch;
      end
      default: begin
        next_state = StFetch;
      end
    endcase
  end

  assign {bus.jump, bus.j_mode, bus.call, bus.ret, bus.ADDRin, bus.FRin, bus.WREGin,
          bus.ALUin1, bus.ALUin2, bus.PCw, bus.ADDRw, bus.FRw, bus.WREGw,
          bus.STATUSw} = o_word;

endmodule

// File: tb/tb_frank_control_unit.sv
module tb_frank_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  frank_control_unit_if bus ();

  frank_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: each opcode is a short program of output words, one per cycle.
  logic [15:0] word_tbl [16][3];
  int          len_tbl  [16];
  // phase: 0 fetch, 1 first execute, 2 second execute, 3 idle cycle after reset
  int          phase;

  typedef struct {
    logic        r;
    logic [3:0]  op;
    logic [1:0]  st_now;
    logic [15:0] o_now;
    logic [1:0]  st_next;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [15:0] o_now();
    return {bus.jump, bus.j_mode, bus.call, bus.ret, bus.ADDRin, bus.FRin, bus.WREGin,
            bus.ALUin1, bus.ALUin2, bus.PCw, bus.ADDRw, bus.FRw, bus.WREGw, bus.STATUSw};
  endfunction

  function automatic logic [1:0] phase_code(int ph);
    if (ph == 0) return 2'b01;
    if (ph == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [15:0] model_word(int ph, logic [3:0] op);
    if (ph == 3) return 16'h0000;
    if (ph >= len_tbl[op]) return 16'h0000;
    return word_tbl[op][ph];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, check outputs against the model, clock, advance the model, check state.
  task automatic model_step(input logic r, input logic [3:0] op, input string tag);
    @(negedge clk);
    rst = r;
    bus.control_input = op;
    #1;
    chk($sformatf("%s state op%h", tag, op), {14'd0, dut.r_unit_state}, {14'd0, phase_code(phase)});
    chk($sformatf("%s out op%h ph%0d", tag, op, phase), o_now(), model_word(phase, op));
    @(posedge clk);
    if (r) phase = 3;
    else if (phase == 0) phase = 1;
    else if (phase == 1) phase = (len_tbl[op] == 3) ? 2 : 0;
    else phase = 0;
    #1;
    chk($sformatf("%s next op%h", tag, op), {14'd0, dut.r_unit_state}, {14'd0, phase_code(phase)});
  endtask

  initial begin
    logic [3:0] cur_op;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 3; j++) word_tbl[i][j] = 16'h0000;
      len_tbl[i] = 2;
    end
    word_tbl[1][0] = 16'hB010;
    word_tbl[2][0] = 16'h0810;
    word_tbl[3][0] = 16'h8010;
    word_tbl[4][0] = 16'hC010;
    word_tbl[5][0] = 16'hE010;
    word_tbl[6][1] = 16'h0008;
    word_tbl[7][1] = 16'h0082;
    word_tbl[8][1] = 16'h0004;
    word_tbl[9][1] = 16'h0102;
    word_tbl[10][1] = 16'h0408;
    word_tbl[11][1] = 16'h0043;
    word_tbl[12][1] = 16'h0033;
    word_tbl[13][1] = 16'h0021;
    word_tbl[13][2] = 16'h0204;
    len_tbl[12] = 3;
    len_tbl[13] = 3;

    // {rst, op, state before edge, output before edge, state after edge}
    vecs[0]  = '{1'b0, 4'h0, 2'b00, 16'h0000, 2'b01};
    vecs[1]  = '{1'b0, 4'h1, 2'b01, 16'hB010, 2'b10};
    vecs[2]  = '{1'b0, 4'h1, 2'b10, 16'h0000, 2'b01};
    vecs[3]  = '{1'b0, 4'hC, 2'b01, 16'h0000, 2'b10};
    vecs[4]  = '{1'b0, 4'hC, 2'b10, 16'h0033, 2'b00};
    vecs[5]  = '{1'b0, 4'hC, 2'b00, 16'h0000, 2'b01};
    vecs[6]  = '{1'b0, 4'hD, 2'b01, 16'h0000, 2'b10};
    vecs[7]  = '{1'b0, 4'hD, 2'b10, 16'h0021, 2'b00};
    vecs[8]  = '{1'b0, 4'hD, 2'b00, 16'h0204, 2'b01};
    vecs[9]  = '{1'b1, 4'hD, 2'b01, 16'h0000, 2'b00};
    vecs[10] = '{1'b0, 4'hD, 2'b00, 16'h0000, 2'b01};
    vecs[11] = '{1'b0, 4'hD, 2'b01, 16'h0000, 2'b10};
    vecs[12] = '{1'b1, 4'hC, 2'b10, 16'h0033, 2'b00};
    vecs[13] = '{1'b0, 4'hC, 2'b00, 16'h0000, 2'b01};

    // Initial reset
    bus.control_input = 4'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset state", {14'd0, dut.r_unit_state}, 16'h0000);
    chk("reset out", o_now(), 16'h0000);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = vecs[i].r;
      bus.control_input = vecs[i].op;
      #1;
      chk($sformatf("vec%0d state", i), {14'd0, dut.r_unit_state}, {14'd0, vecs[i].st_now});
      chk($sformatf("vec%0d out", i), o_now(), vecs[i].o_now);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d next", i), {14'd0, dut.r_unit_state}, {14'd0, vecs[i].st_next});
    end

    // Decode sweep from FETCH, opcode held for the whole instruction
    phase = 0;
    for (int op = 0; op < 16; op++) begin
      for (int c = 0; c < len_tbl[op]; c++) model_step(1'b0, 4'(op), "sweep");
    end

    // Randomized: occasional resets and mid-instruction opcode changes
    cur_op = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) cur_op = 4'($urandom_range(0, 15));
      model_step(($urandom_range(0, 24) == 0), cur_op, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
